// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: format selectors, reject
// codes, output buffer depth and the buffered {pc, instr} entry.
package instr_encoder_pkg;

  // Selector values line up with the immediate decoder's format select.
  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_J = 3'd1,
    FMT_U = 3'd2,
    FMT_B = 3'd3,
    FMT_S = 3'd4,
    FMT_R = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE  = 2'd0,
    ERR_RANGE = 2'd1,
    ERR_ALIGN = 2'd2,
    ERR_FMT   = 2'd3
  } err_e;

  localparam int FIFO_DEPTH = 2;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fifo_entry_t;

  // True when v[63:msb] are all copies of one bit, i.e. v fits as a signed
  // (msb+1)-bit value.
  function automatic logic upper_uniform(logic [63:0] v, int unsigned msb);
    logic [63:0] t;
    t = $signed(v) >>> msb;
    return (t == '0) || (t == '1);
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry output buffer holding {pc, instr}; the head entry is presented
// directly and stays put until popped.
module instr_fifo2
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        push,
  input  logic [63:0] push_pc,
  input  logic [31:0] push_instr,
  input  logic        pop,
  output logic        valid,
  output logic        full,
  output logic [63:0] head_pc,
  output logic [31:0] head_instr
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] DEPTH_L = (PTR_W + 1)'(FIFO_DEPTH);

  fifo_entry_t      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   used;

  assign valid      = (used != '0);
  assign full       = (used == DEPTH_L);
  assign head_pc    = mem[rd_ptr].pc;
  assign head_instr = mem[rd_ptr].instr;

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: storage is cleared on reset only because the head is visible on
      // instr/addr and must read zero after reset; a flush leaves it alone.
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      used   <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{pc: push_pc, instr: push_instr};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   used <= used + 1'b1;
        2'b01:   used <= used - 1'b1;
        default: used <= used;
      endcase
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs RISC-V style field bundles into 32-bit instruction words, rejects
// out-of-range or misaligned immediates, and streams {addr, instr} out.
module instr_encoder
  import instr_encoder_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  select_fmt,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [63:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [63:0] addr,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] count
);

  logic [63:0] pc;
  err_e        chk;
  err_e        err_q;
  logic [31:0] packed_word;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  // Readiness comes from registered fullness only, so a pop never frees a
  // slot for an accept in the same cycle.
  assign in_ready = !reset && !start && !full;
  assign accept   = in_valid && in_ready;
  assign push     = accept && (chk == ERR_NONE);
  assign pop      = out_valid && out_ready;
  assign err_code = err_q;

  always_comb begin
    // NOTE: chk gets a default before the case so no path leaves it unassigned
    // and no latch is inferred.
    chk = ERR_NONE;
    case (fmt_e'(select_fmt))
      FMT_I, FMT_S: if (!upper_uniform(imm, 11)) chk = ERR_RANGE;
      FMT_B: begin
        if (imm[0])                        chk = ERR_ALIGN;
        else if (!upper_uniform(imm, 12))  chk = ERR_RANGE;
      end
      FMT_J: begin
        if (imm[0])                        chk = ERR_ALIGN;
        else if (!upper_uniform(imm, 20))  chk = ERR_RANGE;
      end
      FMT_U: if (imm[11:0] != '0 || !upper_uniform(imm, 31)) chk = ERR_RANGE;
      FMT_R: chk = ERR_NONE;
      default: chk = ERR_FMT;
    endcase
  end

  always_comb begin
    packed_word = '0;
    case (fmt_e'(select_fmt))
      FMT_I: packed_word = {imm[11:0], rs1, funct3, rd, opcode};
      FMT_S: packed_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
      FMT_B: packed_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], opcode};
      FMT_U: packed_word = {imm[31:12], rd, opcode};
      FMT_J: packed_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
      FMT_R: packed_word = {funct7, rs2, rs1, funct3, rd, opcode};
      default: packed_word = '0;
    endcase
  end

  instr_fifo2 u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (start),
    .push       (push),
    .push_pc    (pc),
    .push_instr (packed_word),
    .pop        (pop),
    .valid      (out_valid),
    .full       (full),
    .head_pc    (addr),
    .head_instr (instr)
  );

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      pc    <= '0;
      count <= '0;
      err   <= 1'b0;
      err_q <= ERR_NONE;
    end else if (start) begin
      pc    <= base_addr;
      count <= '0;
      err   <= 1'b0;
      err_q <= ERR_NONE;
    end else begin
      err   <= accept && (chk != ERR_NONE);
      err_q <= accept ? chk : ERR_NONE;
      if (push) pc <= pc + 64'd4;
      if (pop && count != 16'hFFFF) count <= count + 16'd1;
    end
  end

endmodule
